sega_pad_reader: RTL and testbench
==================================

Name: sega_pad_reader

Overview:
- Polls a Sega 3-button control pad by driving its select line and sampling the six active-low data pins.
- Produces clean, synchronized, active-high button levels and one-cycle press pulses.
- These feed the game's steering and start logic, replacing direct raw-pin wiring.
- Sits between the pad connector pins and the game top; one instance per pad.

Parameters:
- POLL_CYCLES, 833333: clock cycles between frame starts (60 Hz at 50 MHz); must exceed 2*SETTLE_CYCLES+4.
- SETTLE_CYCLES, 50: cycles waited after each select edge before sampling (1 us at 50 MHz); must be ≥3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pad_in  in  6  raw pad pins, active-low, asynchronous: [0]=up [1]=down [2]=left [3]=right [4]=B/A [5]=C/Start
- pad_select  out  1  select line to the pad
- buttons  out  8  held levels, active-high: [0]=up [1]=down [2]=left [3]=right [4]=A [5]=B [6]=C [7]=start
- pressed  out  8  one-cycle rising-edge pulses, same bit order as buttons
- frame_valid  out  1  one-cycle pulse when buttons/pressed update
- connected  out  1  pad present per last completed frame

Behaviour:
- Reset values: pad_select=1, buttons=0, pressed=0, frame_valid=0, connected=0, FSM=IDLE, all counters 0.
- pad_in passes through a 2-flop synchronizer. All sampling uses the synchronized value, inverted to active-high.
- Poll counter runs freely from 0 to POLL_CYCLES-1 and wraps. It is cleared only by reset. A poll tick occurs on the wrap cycle.
- FSM states:
  - IDLE: pad_select=1. On poll tick → HI_WAIT with settle count 0.
  - HI_WAIT: pad_select=1. Settle count increments each cycle. In the cycle where it equals SETTLE_CYCLES-1, capture shadow up, down, left, right, B, C from pins [0..5], then → LO_WAIT with settle count 0.
  - LO_WAIT: pad_select=0. In the cycle where settle count equals SETTLE_CYCLES-1, capture shadow A=pin[4] and start=pin[5]. In the same cycle, capture detect = both synchronized raw pins [2] and [3] low. Then → UPDATE.
  - UPDATE (one cycle): pad_select=1.
    - Commit connected=detect.
    - If detect: buttons=shadow and pressed=shadow & ~buttons_prev. Otherwise buttons=0 and pressed=0.
    - frame_valid=1. Next state is IDLE.
- pressed and frame_valid are high only during the UPDATE cycle; they are 0 otherwise. buttons holds between frames.
- Frame timeline:
  - pad_select falls SETTLE_CYCLES+1 cycles after the poll tick.
  - frame_valid occurs 2*SETTLE_CYCLES+1 cycles after the poll tick.
- Pin changes during a frame: a pin change after its capture cycle shows up in the next frame only. Up/down/left/right are taken only from the HI phase.
- Disconnect and reconnect:
  - A disconnected pad (pins float high, so detect=0) gives connected=0 and buttons=0 from the next UPDATE.
  - On reconnection, buttons that are already held produce pressed pulses in the first connected frame, since buttons_prev was 0.
- A poll tick while not in IDLE is ignored. The parameter constraint prevents this case.
- Reset asserted mid-frame: on the next edge, outputs and FSM return to reset values and pad_select=1. No partial frame is committed.
- Counter widths are sized with $clog2 of the parameters. No overflow is possible.

Test Plan (sim parameters POLL_CYCLES=200, SETTLE_CYCLES=8):
- Reset, pad idle:
  - Stimulus: pad_in=6'b111111 during HI, pins[2:3]=0 during LO. Release reset.
  - Required: pad_select=1 until the first tick. Falls 9 cycles after the tick. frame_valid 17 cycles after the tick. connected=1, buttons=0, pressed=0.
- Press left plus start:
  - Stimulus: pad model drives pin2=0 when select=1, and pin5=0 when select=0.
  - Required: next frame gives buttons=8'h84, pressed=8'h84 for exactly one cycle. The following frame gives buttons=8'h84, pressed=8'h00.
- Release:
  - Stimulus: return all pins high.
  - Required: next frame gives buttons=8'h00, pressed=8'h00, frame_valid pulse present.
- Disconnect:
  - Stimulus: pad_in=6'b111111 in both phases while right is held beforehand.
  - Required: next frame gives connected=0, buttons=0, pressed=0. Reconnect with right held gives connected=1 and pressed=8'h08.
- Late change:
  - Stimulus: pin3 (right) drops 2 cycles after the HI capture cycle.
  - Required: the current frame has buttons[3]=0. The next frame has buttons[3]=1.
- Mid-frame reset:
  - Stimulus: assert reset for 1 cycle during LO_WAIT.
  - Required: pad_select=1 and all outputs 0 on the following cycle. No frame_valid until one full POLL_CYCLES later.

Source files
------------

// File: rtl/sega_pad_reader.sv
// Sega 3-button pad poller: drives select, samples both phases of the active-low pins,
// and publishes synchronized active-high button levels, press pulses and pad presence.
module sega_pad_reader #(
    parameter int POLL_CYCLES   = 833333,
    parameter int SETTLE_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] pad_in,
    output logic       pad_select,
    output logic [7:0] buttons,
    output logic [7:0] pressed,
    output logic       frame_valid,
    output logic       connected
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_CYCLES - 1);
    localparam logic [PW-1:0] POLL_ONE    = PW'(1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HI_WAIT = 2'd1,
        LO_WAIT = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [SW-1:0]   settle_cnt_r;
    logic [SW-1:0]   settle_next_s;
    logic [PW-1:0]   poll_cnt_r;
    logic            poll_tick_s;
    logic            hi_capture_s;
    logic            lo_capture_s;
    logic [5:0]      pad_meta_r;
    logic [5:0]      pad_sync_r;
    logic [5:0]      pins_s;
    logic [5:0]      shadow_hi_r;
    logic [7:0]      frame_s;
    logic            detect_s;
    logic            pad_select_r;
    logic [7:0]      buttons_r;
    logic [7:0]      pressed_r;
    logic            frame_valid_r;
    logic            connected_r;

    assign pins_s      = ~pad_sync_r;
    assign poll_tick_s = (poll_cnt_r == POLL_LAST);
    // A and start come straight from the LO-phase pins; they are committed on the same edge.
    assign frame_s     = {pins_s[5], shadow_hi_r[5], shadow_hi_r[4], pins_s[4], shadow_hi_r[3:0]};
    assign detect_s    = pins_s[2] & pins_s[3];

    assign pad_select  = pad_select_r;
    assign buttons     = buttons_r;
    assign pressed     = pressed_r;
    assign frame_valid = frame_valid_r;
    assign connected   = connected_r;

    // State and settle counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            settle_cnt_r <= {SW{1'b0}};
        end else begin
            state_r      <= state_next_s;
            settle_cnt_r <= settle_next_s;
        end
    end

    // Next-state, settle count and capture strobes.
    always_comb begin
        state_next_s  = state_r;
        settle_next_s = settle_cnt_r;
        hi_capture_s  = 1'b0;
        lo_capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (poll_tick_s) begin
                    state_next_s  = HI_WAIT;
                    settle_next_s = {SW{1'b0}};
                end else begin
                    state_next_s  = IDLE;
                end
            end
            HI_WAIT: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    hi_capture_s  = 1'b1;
                    state_next_s  = LO_WAIT;
                    settle_next_s = {SW{1'b0}};
                end else begin
                    settle_next_s = settle_cnt_r + SETTLE_ONE;
                end
            end
            LO_WAIT: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    lo_capture_s  = 1'b1;
                    state_next_s  = UPDATE;
                    settle_next_s = {SW{1'b0}};
                end else begin
                    settle_next_s = settle_cnt_r + SETTLE_ONE;
                end
            end
            UPDATE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s  = IDLE;
                settle_next_s = {SW{1'b0}};
            end
        endcase
    end

    // Synchronizer, poll counter, HI shadow and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pad_meta_r    <= 6'b111111;
            pad_sync_r    <= 6'b111111;
            poll_cnt_r    <= {PW{1'b0}};
            shadow_hi_r   <= 6'b000000;
            pad_select_r  <= 1'b1;
            buttons_r     <= 8'h00;
            pressed_r     <= 8'h00;
            frame_valid_r <= 1'b0;
            connected_r   <= 1'b0;
        end else begin
            pad_meta_r    <= pad_in;
            pad_sync_r    <= pad_meta_r;
            poll_cnt_r    <= poll_tick_s ? {PW{1'b0}} : (poll_cnt_r + POLL_ONE);
            pad_select_r  <= (state_next_s != LO_WAIT);
            pressed_r     <= 8'h00;
            frame_valid_r <= 1'b0;
            if (hi_capture_s) begin
                shadow_hi_r <= pins_s;
            end
            // buttons_r still holds the previous frame here, giving the edge detect.
            if (lo_capture_s) begin
                frame_valid_r <= 1'b1;
                connected_r   <= detect_s;
                buttons_r     <= detect_s ? frame_s : 8'h00;
                pressed_r     <= detect_s ? (frame_s & ~buttons_r) : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_sega_pad_reader.sv
// Scoreboard bench for sega_pad_reader: a pad model answers the select line, expected
// frames are queued by the stimulus and checked by a negedge monitor.
module tb_sega_pad_reader;

    localparam int POLL   = 200;
    localparam int SETTLE = 8;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] p;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] hi_raw = 6'b111111;
    logic [5:0] lo_raw = 6'b110011;
    wire  [5:0] pad_in;
    logic       pad_select;
    logic [7:0] buttons;
    logic [7:0] pressed;
    logic       frame_valid;
    logic       connected;

    int   cyc = -1;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    sega_pad_reader #(.POLL_CYCLES(POLL), .SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .pad_in      (pad_in),
        .pad_select  (pad_select),
        .buttons     (buttons),
        .pressed     (pressed),
        .frame_valid (frame_valid),
        .connected   (connected)
    );

    assign pad_in = pad_select ? hi_raw : lo_raw;

    always #5 clk = ~clk;

    // Cycles since reset; equals the DUT poll count while reset is low.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: frame timeline from the cycle count, frame contents from the scoreboard.
    always @(negedge clk) begin
        int   ph;
        logic fv_exp;
        logic sel_exp;
        exp_t e;
        if (cyc >= 0) begin
            ph      = cyc % POLL;
            fv_exp  = (cyc >= POLL) && (ph == 2 * SETTLE);
            sel_exp = !((cyc >= POLL) && (ph >= SETTLE) && (ph < 2 * SETTLE));
            check("pad_select", {31'd0, pad_select}, {31'd0, sel_exp});
            check("frame_valid", {31'd0, frame_valid}, {31'd0, fv_exp});
            if (!fv_exp) check("pressed_idle", {24'd0, pressed}, 32'd0);
            if (cyc == 0) begin
                check("reset_buttons", {24'd0, buttons}, 32'd0);
                check("reset_connected", {31'd0, connected}, 32'd0);
            end
            if (frame_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("buttons", {24'd0, buttons}, {24'd0, e.b});
                    check("pressed", {24'd0, pressed}, {24'd0, e.p});
                    check("connected", {31'd0, connected}, {31'd0, e.c});
                end
            end
        end
    end

    task automatic expect_frame(input logic [7:0] b, input logic [7:0] p, input logic c);
        exp_t e;
        e.b = b;
        e.p = p;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_valid !== 1'b1 && n < 500);
        check("frame_seen", {31'd0, frame_valid}, 32'd1);
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % POLL) != ph && n < 500);
        check("phase_reached", cyc % POLL, ph);
    endtask

    initial begin
        // Reset with an idle, connected pad.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_frame(8'h00, 8'h00, 1'b1);
        wait_frame();

        // Left (HI pin2) plus start (LO pin5).
        hi_raw = 6'b111011;
        lo_raw = 6'b010011;
        expect_frame(8'h84, 8'h84, 1'b1);
        expect_frame(8'h84, 8'h00, 1'b1);
        wait_frame();
        wait_frame();

        // Release.
        hi_raw = 6'b111111;
        lo_raw = 6'b110011;
        expect_frame(8'h00, 8'h00, 1'b1);
        wait_frame();

        // Hold right, disconnect, reconnect with right still held.
        hi_raw = 6'b110111;
        expect_frame(8'h08, 8'h08, 1'b1);
        wait_frame();
        hi_raw = 6'b111111;
        lo_raw = 6'b111111;
        expect_frame(8'h00, 8'h00, 1'b0);
        wait_frame();
        hi_raw = 6'b110111;
        lo_raw = 6'b110011;
        expect_frame(8'h08, 8'h08, 1'b1);
        wait_frame();

        // Late change: right drops two cycles after the HI capture cycle.
        hi_raw = 6'b111111;
        expect_frame(8'h00, 8'h00, 1'b1);
        wait_frame();
        expect_frame(8'h00, 8'h00, 1'b1);
        expect_frame(8'h08, 8'h08, 1'b1);
        wait_phase(SETTLE + 1);
        hi_raw = 6'b110111;
        wait_frame();
        wait_frame();

        // One-cycle reset during LO_WAIT; the interrupted frame must never appear.
        wait_phase(SETTLE + 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expect_frame(8'h08, 8'h08, 1'b1);
        wait_frame();

        repeat (4) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
